// File: rtl/track_view_pkg.sv
// track_view_pkg
// Shared colour constants, player palette, start-line bounds and the
// region encoding used between the two pipeline stages of track_view.
package track_view_pkg;

  // RGB444 colours
  localparam logic [11:0] GRASS     = 12'h0A0;
  localparam logic [11:0] ASPHALT   = 12'h666;
  localparam logic [11:0] LINE_W    = 12'hFFF;
  localparam logic [11:0] LINE_B    = 12'h000;
  localparam logic [11:0] OPP_COLOR = 12'hF0F;
  localparam logic [11:0] BLACK     = 12'h000;

  // Player palette; entry i is selected by sprite_type[2:0] == i.
  localparam logic [7:0][11:0] PALETTE = {
    12'hFFF, 12'hF80, 12'h0FF, 12'h80F,
    12'hFF0, 12'h0F0, 12'h00F, 12'hF00
  };

  // Start-line row band, y in [LINE_Y_LO, LINE_Y_HI)
  localparam int LINE_Y_LO = 240;
  localparam int LINE_Y_HI = 248;

  // Track region of a pixel as classified in stage 1
  typedef enum logic [1:0] {
    RGN_OUT     = 2'd0,  // outside the world window
    RGN_GRASS   = 2'd1,
    RGN_ASPHALT = 2'd2,
    RGN_LINE    = 2'd3   // start-line chequer band
  } region_t;

endpackage

// File: rtl/track_view_sprite_hit.sv
// sprite_hit
// Combinational square hit test for one kart sprite.
// Ports:
//   hcount, vcount : raster position
//   sx, sy         : sprite top-left corner
//   hit            : raster position lies inside the SIZE x SIZE square
//   off_x, off_y   : local offset inside the square (valid when hit)
module sprite_hit #(
  parameter int SIZE = 16
) (
  input  logic [10:0]               hcount,
  input  logic [9:0]                vcount,
  input  logic [8:0]                sx,
  input  logic [8:0]                sy,
  output logic                      hit,
  output logic [$clog2(SIZE)-1:0]   off_x,
  output logic [$clog2(SIZE)-1:0]   off_y
);
  localparam int OW = $clog2(SIZE);

  logic [10:0] w_sx;
  logic [10:0] w_sy;
  logic [10:0] w_v;
  logic [10:0] w_sx_end;
  logic [10:0] w_sy_end;

  // 11-bit arithmetic: sx + SIZE cannot wrap, so sprites near 511 clip cleanly
  assign w_sx     = {2'b00, sx};
  assign w_sy     = {2'b00, sy};
  assign w_v      = {1'b0, vcount};
  assign w_sx_end = w_sx + 11'(SIZE);
  assign w_sy_end = w_sy + 11'(SIZE);

  assign hit = (hcount >= w_sx) && (hcount < w_sx_end) &&
               (w_v >= w_sy) && (w_v < w_sy_end);

  // SIZE is a power of two, so the low bits of the difference are exact
  assign off_x = hcount[OW-1:0] - sx[OW-1:0];
  assign off_y = vcount[OW-1:0] - sy[OW-1:0];

endmodule

// File: rtl/track_view.sv
// track_view
// Two-stage per-pixel renderer for the top-down race view: procedural track
// (grass / asphalt / start line) with player and opponent kart squares on top.
// Option macro: TRACK_VIEW_OUTLINE_EN draws a black 1-pixel border on sprites.
// Ports:
//   clk_in, rst_in          : clock, synchronous active-high reset
//   hcount_in, vcount_in    : raster position
//   sprite_type             : player palette select ([3] ignored)
//   player_x/y, opponent_x/y: sprite top-left corners
//   pixel_out               : RGB444, 2 cycles after its input
module track_view
  import track_view_pkg::*;
#(
  parameter int SPRITE_SIZE = 16,
  parameter int WORLD_SIZE  = 512,
  parameter int OUTER_LO    = 32,
  parameter int OUTER_HI    = 480,
  parameter int INNER_LO    = 96,
  parameter int INNER_HI    = 416
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [3:0]  sprite_type,
  input  logic [8:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic [8:0]  opponent_x,
  input  logic [8:0]  opponent_y,
  output logic [11:0] pixel_out
);
  localparam int OFF_W = $clog2(SPRITE_SIZE);

`ifdef TRACK_VIEW_OUTLINE_EN
  localparam logic OUTLINE = 1'b1;
`else
  localparam logic OUTLINE = 1'b0;
`endif

  logic [10:0]      w_x;
  logic [10:0]      w_y;
  logic             w_in_win;
  logic             w_outer;
  logic             w_inner;
  logic             w_line;
  region_t          w_region;
  logic             w_p_hit;
  logic             w_o_hit;
  logic [OFF_W-1:0] w_p_ox, w_p_oy, w_o_ox, w_o_oy;
  logic             w_p_edge;
  logic             w_o_edge;

  assign w_x = hcount_in;
  assign w_y = {1'b0, vcount_in};

  assign w_in_win = (w_x < 11'(WORLD_SIZE)) && (w_y < 11'(WORLD_SIZE));
  assign w_outer  = (w_x >= 11'(OUTER_LO)) && (w_x < 11'(OUTER_HI)) &&
                    (w_y >= 11'(OUTER_LO)) && (w_y < 11'(OUTER_HI));
  assign w_inner  = (w_x >= 11'(INNER_LO)) && (w_x < 11'(INNER_HI)) &&
                    (w_y >= 11'(INNER_LO)) && (w_y < 11'(INNER_HI));
  assign w_line   = (w_x >= 11'(OUTER_LO)) && (w_x < 11'(INNER_LO)) &&
                    (w_y >= 11'(LINE_Y_LO)) && (w_y < 11'(LINE_Y_HI));

  always_comb begin
    w_region = RGN_GRASS;
    if (!w_in_win)               w_region = RGN_OUT;
    else if (w_line)             w_region = RGN_LINE;
    else if (w_outer && !w_inner) w_region = RGN_ASPHALT;
  end

  sprite_hit #(.SIZE(SPRITE_SIZE)) u_player_hit (
    .hcount (hcount_in),
    .vcount (vcount_in),
    .sx     (player_x),
    .sy     (player_y),
    .hit    (w_p_hit),
    .off_x  (w_p_ox),
    .off_y  (w_p_oy)
  );

  sprite_hit #(.SIZE(SPRITE_SIZE)) u_opponent_hit (
    .hcount (hcount_in),
    .vcount (vcount_in),
    .sx     (opponent_x),
    .sy     (opponent_y),
    .hit    (w_o_hit),
    .off_x  (w_o_ox),
    .off_y  (w_o_oy)
  );

  assign w_p_edge = (w_p_ox == '0) || (w_p_ox == OFF_W'(SPRITE_SIZE - 1)) ||
                    (w_p_oy == '0) || (w_p_oy == OFF_W'(SPRITE_SIZE - 1));
  assign w_o_edge = (w_o_ox == '0) || (w_o_ox == OFF_W'(SPRITE_SIZE - 1)) ||
                    (w_o_oy == '0) || (w_o_oy == OFF_W'(SPRITE_SIZE - 1));

  // Stage 1 registers
  region_t    r_region;
  logic       r_p_hit;
  logic       r_o_hit;
  logic       r_p_edge;
  logic       r_o_edge;
  logic [2:0] r_x_lo;
  logic [2:0] r_y_lo;
  logic [3:0] r_type;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_region <= RGN_OUT;
      r_p_hit  <= 1'b0;
      r_o_hit  <= 1'b0;
      r_p_edge <= 1'b0;
      r_o_edge <= 1'b0;
      r_x_lo   <= '0;
      r_y_lo   <= '0;
      r_type   <= '0;
    end else begin
      r_region <= w_region;
      // sprites are never drawn outside the window
      r_p_hit  <= w_p_hit && w_in_win;
      r_o_hit  <= w_o_hit && w_in_win;
      r_p_edge <= w_p_edge && OUTLINE;
      r_o_edge <= w_o_edge && OUTLINE;
      r_x_lo   <= hcount_in[2:0];
      r_y_lo   <= vcount_in[2:0];
      r_type   <= sprite_type;
    end
  end

  // Only bit 2 of the chequer coordinates and the low 3 palette bits matter.
  logic w_unused_bits;
  assign w_unused_bits = &{r_x_lo[1:0], r_y_lo[1:0], r_type[3]};

  // Stage 2: colour mux, priority player > opponent > track
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_out <= BLACK;
    end else if (r_p_hit) begin
      pixel_out <= r_p_edge ? BLACK : PALETTE[r_type[2:0]];
    end else if (r_o_hit) begin
      pixel_out <= r_o_edge ? BLACK : OPP_COLOR;
    end else begin
      case (r_region)
        RGN_LINE:    pixel_out <= (r_x_lo[2] ^ r_y_lo[2]) ? LINE_W : LINE_B;
        RGN_ASPHALT: pixel_out <= ASPHALT;
        RGN_GRASS:   pixel_out <= GRASS;
        default:     pixel_out <= BLACK;
      endcase
    end
  end

endmodule

// File: tb/tb_track_view.sv
module tb_track_view;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [3:0]  sprite_type = '0;
  logic [8:0]  player_x = '0;
  logic [8:0]  player_y = '0;
  logic [8:0]  opponent_x = 9'd200;
  logic [8:0]  opponent_y = 9'd200;
  logic [11:0] pixel_out;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  track_view dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .sprite_type (sprite_type),
    .player_x    (player_x),
    .player_y    (player_y),
    .opponent_x  (opponent_x),
    .opponent_y  (opponent_y),
    .pixel_out   (pixel_out)
  );

  always #5 clk_in = ~clk_in;

`ifdef TRACK_VIEW_OUTLINE_EN
  localparam bit OL = 1'b1;
`else
  localparam bit OL = 1'b0;
`endif

  function automatic logic [11:0] pal(input int t);
    case (t % 8)
      0: return 12'hF00;
      1: return 12'h00F;
      2: return 12'h0F0;
      3: return 12'hFF0;
      4: return 12'h80F;
      5: return 12'h0FF;
      6: return 12'hF80;
      default: return 12'hFFF;
    endcase
  endfunction

  // Reference pixel written directly from the behavioural description
  function automatic logic [11:0] ref_pixel(input int x, input int y);
    int px, py, ox, oy, t;
    bit p, o, pe, oe;
    px = player_x; py = player_y; ox = opponent_x; oy = opponent_y;
    t  = sprite_type;
    if (x >= 512 || y >= 512) return 12'h000;
    p  = (x >= px) && (x < px + 16) && (y >= py) && (y < py + 16);
    o  = (x >= ox) && (x < ox + 16) && (y >= oy) && (y < oy + 16);
    pe = (x == px) || (x == px + 15) || (y == py) || (y == py + 15);
    oe = (x == ox) || (x == ox + 15) || (y == oy) || (y == oy + 15);
    if (p) return (OL && pe) ? 12'h000 : pal(t);
    if (o) return (OL && oe) ? 12'h000 : 12'hF0F;
    if (x >= 32 && x < 96 && y >= 240 && y < 248)
      return (((x / 4) ^ (y / 4)) & 1) ? 12'hFFF : 12'h000;
    if (x >= 32 && x < 480 && y >= 32 && y < 480 &&
        !(x >= 96 && x < 416 && y >= 96 && y < 416))
      return 12'h666;
    return 12'h0A0;
  endfunction

  // Called at posedge+1: drive one pixel, queue its expectation, advance a
  // cycle, then check the output that belongs to the pixel two steps back.
  task automatic step(input logic r, input int x, input int y,
                      input logic [11:0] e, input string t);
    logic [11:0] ex;
    string       tg;
    rst_in    = r;
    hcount_in = 11'(x);
    vcount_in = 10'(y);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 2) begin
      ex = exp_q.pop_front();
      tg = tag_q.pop_front();
      total++;
      assert (pixel_out === ex) else begin
        bad++;
        $error("FAIL %s: pixel_out=%h expected=%h", tg, pixel_out, ex);
      end
    end
  endtask

  initial begin
    @(posedge clk_in);
    #1;

    // Reset held then released; pixel would be grass if not in reset
    player_x = 9'd0; player_y = 9'd0; opponent_x = 9'd40; opponent_y = 9'd40;
    sprite_type = 4'd1;
    for (int i = 0; i < 4; i++) step(1'b1, 20, 20, 12'h000, "reset_hold");
    step(1'b0, 20, 20, 12'h0A0, "reset_first");
    step(1'b0, 79, 79, 12'h666, "reset_second");

    // 80x80 sweep, x outer loop, y inner loop
    for (int x = 0; x < 80; x++)
      for (int y = 0; y < 80; y++)
        step(1'b0, x, y, ref_pixel(x, y), "sweep");

    // Directed sweep points with fixed expectations
    step(1'b0, 8, 8,   12'h00F, "player_fill");
    step(1'b0, 47, 47, 12'hF0F, "opp_fill");
    step(1'b0, 20, 20, 12'h0A0, "grass");
    step(1'b0, 79, 79, 12'h666, "asphalt");

    // Mid-stream reset discards the in-flight pixel
    step(1'b0, 79, 79, 12'h666, "pre_rst_ok");
    step(1'b0, 20, 20, 12'h000, "inflight_dropped");
    step(1'b1, 79, 79, 12'h000, "midrst");
    step(1'b0, 79, 79, 12'h666, "post_rst");

    // Overlap: player covers opponent; sprite_type[3] ignored
    player_x = 9'd40; player_y = 9'd40; opponent_x = 9'd48; opponent_y = 9'd48;
    sprite_type = 4'd3;
    step(1'b0, 50, 50, 12'hFF0, "overlap_t3");
    sprite_type = 4'd9;
    step(1'b0, 50, 50, 12'h00F, "overlap_t9");
    step(1'b0, 60, 60, 12'hF0F, "overlap_opp_only");
    sprite_type = 4'd6;
    step(1'b0, 45, 45, 12'hF80, "type_change");

    // Start line with sprites far away
    player_x = 9'd300; player_y = 9'd300; opponent_x = 9'd350; opponent_y = 9'd350;
    step(1'b0, 32, 240,  12'h000, "line_black");
    step(1'b0, 36, 240,  12'hFFF, "line_white");
    step(1'b0, 95, 247,  12'h000, "line_corner");
    step(1'b0, 96, 240,  12'h0A0, "line_end");
    step(1'b0, 100, 240, 12'h0A0, "infield");
    step(1'b0, 40, 248,  12'h666, "below_line");

    // Window and clipping
    step(1'b0, 600, 10, 12'h000, "outside_h");
    step(1'b0, 10, 600, 12'h000, "outside_v");
    player_x = 9'd505; player_y = 9'd100; sprite_type = 4'd1;
    step(1'b0, 511, 105, 12'h00F, "clip_inside");
    step(1'b0, 515, 105, 12'h000, "clip_outside");
    step(1'b0, 512, 105, 12'h000, "clip_edge");

    // Outline feature (or solid fill when disabled)
    player_x = 9'd0; player_y = 9'd0; sprite_type = 4'd2;
    step(1'b0, 0, 5,  OL ? 12'h000 : 12'h0F0, "outline_edge");
    step(1'b0, 15, 5, OL ? 12'h000 : 12'h0F0, "outline_far_edge");
    step(1'b0, 5, 5,  12'h0F0, "outline_interior");

    // Flush the pipeline
    step(1'b0, 600, 0, 12'h000, "flush0");
    step(1'b0, 600, 0, 12'h000, "flush1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
